// File: rtl/lifi_codeword_deserializer_pkg.sv
// rtl/lifi_codeword_deserializer_pkg.sv - shared Li-Fi framing definitions
//
// Purpose: FSM state encodings and default framing parameters shared by the
//   Li-Fi receive/transmit blocks, plus a small width helper.
// Ports: none (package).

package lifi_codeword_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } lifi_state_t;

  localparam int   LIFI_CW_WIDTH    = 7;
  localparam logic LIFI_START_LEVEL = 1'b1;
  localparam logic LIFI_STOP_LEVEL  = 1'b0;

  // Width of an index that counts 0..n-1 (never less than 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lifi_sat_counter.sv
// rtl/lifi_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses and sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   1      rising-edge clock
//   clear  in   1      synchronous clear, dominant over inc
//   inc    in   1      add one this cycle (ignored once saturated)
//   count  out  WIDTH  current count

module lifi_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lifi_codeword_deserializer.sv
// rtl/lifi_codeword_deserializer.sv - OOK bit-stream framer feeding the Hamming(7,4) decoder
//
// Purpose: frames start bit + CW_WIDTH data bits (LSB first) + stop bit from the
//   strobed line bits, hands each good codeword to a one-entry valid/ready buffer,
//   and flags framing errors and overruns with a saturating error count.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous active-high reset
//   rx_bit     in   1          recovered line bit, used only when rx_bit_en=1
//   rx_bit_en  in   1          one-cycle strobe per received bit
//   codeword   out  CW_WIDTH   buffered codeword, rx data bit k -> codeword[k]
//   valid      out  1          codeword holds an unconsumed frame
//   ready      in   1          consumer accepts when valid && ready
//   frame_err  out  1          one-cycle pulse: bad stop bit, frame discarded
//   overrun    out  1          one-cycle pulse: frame finished while buffer full
//   err_count  out  ERR_CNT_W  saturating count of frame_err + overrun pulses

module lifi_codeword_deserializer
  import lifi_codeword_deserializer_pkg::*;
#(
  parameter int   CW_WIDTH    = LIFI_CW_WIDTH,
  parameter logic START_LEVEL = LIFI_START_LEVEL,
  parameter logic STOP_LEVEL  = LIFI_STOP_LEVEL,
  parameter int   ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic                 rx_bit_en,
  output logic [CW_WIDTH-1:0]  codeword,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int               IDX_W    = idx_width(CW_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_WIDTH - 1);

  lifi_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CW_WIDTH-1:0] shift_q, shift_d;
  logic                frame_done;
  logic                stop_bad;

  logic [CW_WIDTH-1:0] codeword_q;
  logic                valid_q;
  logic                frame_err_q;
  logic                overrun_q;
  logic                accept_new;
  logic                drop_new;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // FSM next state; nothing moves without a bit strobe
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    if (rx_bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_bit == START_LEVEL) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = rx_bit;
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (rx_bit == STOP_LEVEL) begin
            frame_done = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // A finished frame is taken if the buffer is empty or is being drained in
  // the same cycle; otherwise the held word wins and the new one is dropped.
  assign accept_new = frame_done && (!valid_q || ready);
  assign drop_new   = frame_done && valid_q && !ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      codeword_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= drop_new;
      if (accept_new) begin
        codeword_q <= shift_q;
        valid_q    <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Counts on the same edge that raises the pulse, so the count and the
  // pulse become visible together.
  lifi_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stop_bad | drop_new),
    .count (err_count)
  );

  assign codeword  = codeword_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lifi_codeword_deserializer.sv
// tb/tb_lifi_codeword_deserializer.sv - self-checking bench for lifi_codeword_deserializer

module tb_lifi_codeword_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic       rx_bit_en;
  logic       ready;
  logic [6:0] codeword, codeword2;
  logic       valid, valid2;
  logic       frame_err, frame_err2;
  logic       overrun, overrun2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lifi_codeword_deserializer dut (
    .clk       (clk),
    .reset     (reset),
    .rx_bit    (rx_bit),
    .rx_bit_en (rx_bit_en),
    .codeword  (codeword),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_count (err_count)
  );

  lifi_codeword_deserializer #(.ERR_CNT_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .rx_bit    (rx_bit),
    .rx_bit_en (rx_bit_en),
    .codeword  (codeword2),
    .valid     (valid2),
    .ready     (ready),
    .frame_err (frame_err2),
    .overrun   (overrun2),
    .err_count (err_count2)
  );

  // Observer: records transfers and pulse events at the clock edge.
  logic [6:0] got_q[$];
  int   ferr_seen = 0;
  int   ovr_seen = 0;
  int   long_pulses = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  always @(posedge clk) begin
    if (valid && ready) got_q.push_back(codeword);
    if (frame_err) ferr_seen <= ferr_seen + 1;
    if (overrun) ovr_seen <= ovr_seen + 1;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) long_pulses <= long_pulses + 1;
    fe_prev <= frame_err;
    ov_prev <= overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Called at a negedge; returns at the negedge after the strobed posedge.
  task automatic strobe(input logic b);
    rx_bit    = b;
    rx_bit_en = 1'b1;
    @(negedge clk);
    rx_bit_en = 1'b0;
  endtask

  // rdy_stop < 0 leaves ready alone; otherwise ready is set with the stop bit.
  task automatic send_frame(input logic [6:0] d, input logic stop, input int max_gap,
                            input int rdy_stop);
    for (int i = 0; i < 9; i++) begin
      logic b;
      if (i == 0) b = 1'b1;
      else if (i < 8) b = d[i-1];
      else b = stop;
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          rx_bit = 1'($urandom);
          @(negedge clk);
        end
      end
      if (i == 8 && rdy_stop >= 0) ready = rdy_stop[0];
      strobe(b);
    end
  endtask

  task automatic do_reset();
    rx_bit_en = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  initial begin
    int base_got, base_fe, base_ov;
    logic [6:0] exp_q[$];
    logic       held;
    logic [6:0] held_word;
    int         exp_fe, exp_ov;

    reset = 1'b1; rx_bit = 1'b0; rx_bit_en = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_codeword", codeword, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame, ready high
    ready = 1'b1;
    base_got = got_q.size();
    send_frame(7'h65, 1'b0, 0, -1);
    chk("t1_valid_latency", valid, 1);
    chk("t1_codeword", codeword, 7'b1100101);
    @(negedge clk);
    chk("t1_valid_drop", valid, 0);
    chk("t1_xfer_cnt", got_q.size() - base_got, 1);
    chk("t1_xfer_word", got_q[base_got], 7'h65);
    chk("t1_err_count", err_count, 0);

    // 2: bad stop bit, then a good frame
    send_frame(7'h65, 1'b1, 0, -1);
    chk("t2_frame_err", frame_err, 1);
    chk("t2_valid", valid, 0);
    chk("t2_err_count", err_count, 1);
    @(negedge clk);
    chk("t2_frame_err_1cyc", frame_err, 0);
    send_frame(7'h3C, 1'b0, 2, -1);
    chk("t2_next_valid", valid, 1);
    chk("t2_next_word", codeword, 7'h3C);
    @(negedge clk);

    // 3: overrun with consumer stalled
    do_reset();
    ready = 1'b0;
    send_frame(7'h35, 1'b0, 0, -1);
    chk("t3_valid", valid, 1);
    chk("t3_word", codeword, 7'h35);
    send_frame(7'h4A, 1'b0, 0, -1);
    chk("t3_overrun", overrun, 1);
    chk("t3_word_kept", codeword, 7'h35);
    chk("t3_valid_kept", valid, 1);
    chk("t3_err_count", err_count, 1);
    @(negedge clk);
    chk("t3_overrun_1cyc", overrun, 0);
    base_got = got_q.size();
    ready = 1'b1;
    @(negedge clk);
    chk("t3_drained", valid, 0);
    chk("t3_xfer_cnt", got_q.size() - base_got, 1);
    chk("t3_xfer_word", got_q[base_got], 7'h35);

    // 4: drain and refill on the stop-strobe cycle
    do_reset();
    ready = 1'b0;
    base_got = got_q.size();
    send_frame(7'h11, 1'b0, 0, -1);
    send_frame(7'h6E, 1'b0, 0, 1);
    chk("t4_no_overrun", overrun, 0);
    chk("t4_valid", valid, 1);
    chk("t4_word", codeword, 7'h6E);
    @(negedge clk);
    chk("t4_xfer_cnt", got_q.size() - base_got, 2);
    chk("t4_xfer_first", got_q[base_got], 7'h11);
    chk("t4_xfer_second", got_q[base_got+1], 7'h6E);
    chk("t4_err_count", err_count, 0);

    // 5: reset mid-frame discards partial frame
    do_reset();
    ready = 1'b1;
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    do_reset();
    base_got = got_q.size(); base_fe = ferr_seen; base_ov = ovr_seen;
    send_frame(7'h2B, 1'b0, 0, -1);
    @(negedge clk);
    chk("t5_xfer_cnt", got_q.size() - base_got, 1);
    chk("t5_xfer_word", got_q[base_got], 7'h2B);
    chk("t5_no_ferr", ferr_seen - base_fe, 0);
    chk("t5_no_ovr", ovr_seen - base_ov, 0);
    chk("t5_err_count", err_count, 0);

    // 6: saturation with a 2-bit counter, gapped strobes
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(7'($urandom_range(127, 0)), 1'b1, 7, -1);
      @(negedge clk);
      chk($sformatf("t6_cnt2_%0d", k), err_count2, sat3(k));
      chk($sformatf("t6_cnt8_%0d", k), err_count, k);
      chk($sformatf("t6_valid_%0d", k), valid, 0);
    end

    // 7: random frames against a frame-level one-entry buffer model
    do_reset();
    base_got = got_q.size(); base_fe = ferr_seen; base_ov = ovr_seen;
    held = 1'b0; held_word = '0; exp_fe = 0; exp_ov = 0;
    for (int f = 0; f < 40; f++) begin
      logic       r, good;
      logic [6:0] d;
      int         n_idle;
      r = 1'($urandom);
      ready = r;
      if (r && held) begin
        exp_q.push_back(held_word);
        held = 1'b0;
      end
      n_idle = $urandom_range(2, 0);
      repeat (n_idle) strobe(1'b0);
      d    = 7'($urandom_range(127, 0));
      good = ($urandom_range(4, 0) != 0);
      send_frame(d, !good, 3, -1);
      if (!good) exp_fe++;
      else if (held) exp_ov++;
      else if (r) exp_q.push_back(d);
      else begin
        held = 1'b1;
        held_word = d;
      end
      @(negedge clk);
    end
    ready = 1'b1;
    if (held) exp_q.push_back(held_word);
    repeat (3) @(negedge clk);
    chk("t7_xfer_cnt", got_q.size() - base_got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_got + i < got_q.size())
        chk($sformatf("t7_word_%0d", i), got_q[base_got+i], exp_q[i]);
    end
    chk("t7_ferr_cnt", ferr_seen - base_fe, exp_fe);
    chk("t7_ovr_cnt", ovr_seen - base_ov, exp_ov);
    chk("t7_err_count", err_count, exp_fe + exp_ov);
    chk("t7_err_count2", err_count2, sat3(exp_fe + exp_ov));
    chk("pulse_width", long_pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
